// File: rtl/bin2_ascii_hex_tx.sv
// bin2_ascii_hex_tx
// Prints a binary word as ASCII hex characters, most-significant nibble
// first, one character per valid/ready transfer. An optional terminator
// character follows the last digit.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   word to print (NIBBLES*4 bits)
//   in_valid   in   in_data is valid
//   in_ready   out  block is idle and can accept a word
//   out_char   out  ASCII character (registered)
//   out_valid  out  out_char is valid (registered)
//   out_ready  in   downstream consumes out_char
//   busy       out  a word is being emitted
//   done       out  one-cycle pulse after the final character transfers
module bin2_ascii_hex_tx #(
  parameter int             NIBBLES   = 4,
  parameter bit             UPPER     = 1'b0,
  parameter bit             TERM_EN   = 1'b1,
  parameter logic [7:0]     TERM_CHAR = 8'h0d
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NIBBLES*4-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_char,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = NIBBLES * 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    TERM  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_shift, w_shift_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;
  logic [7:0]      r_char,  w_char_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_done,  w_done_nxt;
  logic [W-1:0]    w_shift_left;
  logic            w_xfer;

  // Nibble to ASCII hex digit; case of a-f selected by UPPER.
  function automatic logic [7:0] enc(input logic [3:0] n);
    logic [7:0] base;
    if (n <= 4'd9) begin
      enc = 8'h30 + {4'h0, n};
    end else begin
      base = UPPER ? 8'h41 : 8'h61;
      enc  = base + {4'h0, n} - 8'h0a;
    end
  endfunction

  assign w_shift_left = r_shift << 4;
  assign w_xfer       = r_valid & out_ready;

  // Next-state and next-output logic for the emit FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_char_nxt  = r_char;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_shift_nxt = in_data;
          w_cnt_nxt   = CW'(NIBBLES - 1);
          w_char_nxt  = enc(in_data[W-1 -: 4]);
          w_valid_nxt = 1'b1;
          w_state_nxt = DIGIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DIGIT: begin
        if (w_xfer) begin
          if (r_cnt != '0) begin
            // Next digit comes from the top nibble after the shift.
            w_shift_nxt = w_shift_left;
            w_cnt_nxt   = r_cnt - CW'(1);
            w_char_nxt  = enc(w_shift_left[W-1 -: 4]);
          end else if (TERM_EN) begin
            w_char_nxt  = TERM_CHAR;
            w_state_nxt = TERM;
          end else begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = DIGIT;
        end
      end
      TERM: begin
        if (w_xfer) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = TERM;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears a partial word without done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_char  <= w_char_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_char  = r_char;
  assign out_valid = r_valid;
  assign done      = r_done;

endmodule

// File: doc/bin2_ascii_hex_tx.md
Name: bin2_ascii_hex_tx

Overview:
Serializes a binary word into ASCII hex characters, most-significant nibble first, one character per handshake. An optional terminator character follows the digits. It sits between a result register and the UART transmit path. It is the inverse of the ASCII-hex input decoder, so the lowercase a-f output round-trips through that decoder.

Parameters:
NIBBLES, 4, number of hex digits emitted per word; data width is NIBBLES*4.
UPPER, 0, 0 emits a-f as 8'h61..8'h66; 1 emits A-F as 8'h41..8'h46.
TERM_EN, 1, 1 appends TERM_CHAR after the last digit; 0 emits digits only.
TERM_CHAR, 8'h0d, terminator character.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  NIBBLES*4  word to print.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a word.
out_char  out  8  ASCII character.
out_valid  out  1  out_char is valid.
out_ready  in  1  downstream consumes out_char.
busy  out  1  a word is being emitted.
done  out  1  one-cycle pulse after the word's final character transfers.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state is asynchronously cleared while rst_n=0.
- Reset values: state=IDLE, out_valid=0, out_char=8'h00, busy=0, done=0, in_ready=1, shift register=0, digit counter=0.
- State machine states: IDLE, DIGIT, TERM.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE:
  - Accept occurs on the edge where in_valid&in_ready.
  - On accept: latch in_data into the shift register and load the counter with NIBBLES-1.
  - On the same edge, register out_char = enc(in_data[top nibble]), set out_valid=1, go to DIGIT.
  - The first character is therefore visible the cycle after accept (1-cycle latency).
- DIGIT:
  - A transfer is out_valid&out_ready at a rising edge.
  - On a transfer with counter>0: shift the word left 4, decrement the counter, present the next digit on the same edge.
  - On a transfer with counter==0 and TERM_EN=1: out_char=TERM_CHAR, go to TERM.
  - On a transfer with counter==0 and TERM_EN=0: out_valid=0, done=1, go to IDLE.
- TERM: on a transfer, out_valid=0, done=1, go to IDLE.
- Back-to-back throughput: with out_ready held at 1, one character transfers per cycle. A 4-digit word plus terminator takes 5 consecutive transfer cycles.
- Backpressure: while out_ready=0, out_char and out_valid hold stable. Valid is never withdrawn before a transfer.
- enc(n) mapping:
  - n<=9: 8'h30+n.
  - n>=10, UPPER=0: 8'h61+(n-10).
  - n>=10, UPPER=1: 8'h41+(n-10).
- done: high exactly one cycle, the cycle after the final transfer, coincident with in_ready returning to 1.
- No overlap: a new word is not accepted in the cycle of the final transfer. The earliest next accept is the cycle done=1.
- in_valid while busy: ignored. in_data may change freely while busy and does not affect the current word.
- Reset mid-word: output returns immediately to reset values. The partial word is discarded and no done is generated.
- Counter width: clog2(NIBBLES), minimum 1 bit. NIBBLES=1 emits one digit then the optional terminator.

Test Plan:
1. Reset then idle: rst_n=0 then 1, in_valid=0 -> in_ready=1, out_valid=0, out_char=8'h00, busy=0, done=0.
2. Basic word: in_data=16'h1a2f accepted, out_ready=1 held -> out_char sequence 8'h31, 8'h61, 8'h32, 8'h66, 8'h0d on 5 consecutive cycles starting 1 cycle after accept. done pulses on the following cycle.
3. Backpressure: in_data=16'h09fa, out_ready toggled 0/1 with random stalls -> out_char holds through stalls. Transferred sequence is 8'h30, 8'h39, 8'h66, 8'h61, 8'h0d with no drops or duplicates.
4. UPPER=1, TERM_EN=0, in_data=16'hbeef -> 8'h42, 8'h45, 8'h45, 8'h46, then out_valid=0 and done=1. A new in_valid held high during the word is accepted only in the done cycle.
5. Reset mid-word: assert rst_n=0 after the second transfer of 16'h1234 -> outputs return to reset values asynchronously and no done pulse occurs. The next word 16'h0000 emits 8'h30 x4 and 8'h0d.
6. Round trip: every nibble 0..f in a word, each output char fed to the ASCII-hex decoder -> decoded nibbles equal in_data, MSB first.
